sram_march_engine: RTL

SRAM_MARCH_ENGINE -- requirements
Module: sram_march_engine

---
 rtl/sram_march_engine.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_march_engine.sv
// March-style SRAM test engine: streams pattern writes and read-compares
// over an address window, logging the first mismatch and an error count.
module sram_march_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              start,
  input  logic [ADDR_W-1:0] sta_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [1:0]        op,
  input  logic [1:0]        pat_mode,
  input  logic [DATA_W-1:0] pattern,
  input  logic [DATA_W-1:0] s_qdata,
  output logic              s_cen,
  output logic              s_wen,
  output logic              s_oen,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_ddata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic              aborted,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  localparam int CW = ADDR_W + 1;
  localparam int XW = (ADDR_W < DATA_W) ? ADDR_W : DATA_W;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic              start_q;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ddata_q, ddata_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic              abrt_q, abrt_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;

  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [ADDR_W-1:0] pa_q [RD_LAT];
  logic [ADDR_W-1:0] pa_d [RD_LAT];
  logic [DATA_W-1:0] pe_q [RD_LAT];
  logic [DATA_W-1:0] pe_d [RD_LAT];

  logic              accept;
  logic              abort;
  logic              last;
  logic              mismatch;
  logic [1:0]        op_n;
  logic [1:0]        mode_n;
  logic [ADDR_W-1:0] addr_nx;

  function automatic logic [DATA_W-1:0] exp_data(
    input logic [ADDR_W-1:0] a,
    input logic [1:0]        m,
    input logic [DATA_W-1:0] p
  );
    logic [DATA_W-1:0] key;
    logic [DATA_W-1:0] r;
    key = '0;
    key[XW-1:0] = a[XW-1:0];
    unique case (m)
      2'b01:   r = p ^ key;
      2'b10:   r = a[0] ? ~p : p;
      default: r = p;
    endcase
    return r;
  endfunction

  // Reserved encodings collapse to the plain variants.
  assign op_n   = (op == 2'b11) ? 2'b00 : op;
  assign mode_n = (pat_mode == 2'b11) ? 2'b00 : pat_mode;

  assign accept = (state_q == S_IDLE) && enable
                && start && !start_q;
  assign abort  = !enable && (state_q == S_WRITE
                || state_q == S_READ
                || state_q == S_DRAIN);
  assign last   = (cnt_q == CW'(1));
  assign addr_nx = addr_q + ADDR_W'(1);

  assign mismatch = pv_q[RD_LAT-1] && !abort
                  && (s_qdata != pe_q[RD_LAT-1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (length == '0)
            state_d = S_DONE;
          else if (op_n == 2'b01)
            state_d = S_READ;
          else
            state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (abort)
          state_d = S_IDLE;
        else if (last)
          state_d = (op_q == 2'b10) ? S_READ : S_DONE;
      end
      S_READ: begin
        if (abort)
          state_d = S_IDLE;
        else if (last)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)
          state_d = S_IDLE;
        else if (last)
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_cen = 1'b1;
    s_wen = 1'b1;
    s_oen = 1'b1;
    busy  = 1'b0;
    unique case (1'b1)
      (state_q == S_WRITE): begin
        s_cen = 1'b0;
        s_wen = 1'b0;
        busy  = 1'b1;
      end
      (state_q == S_READ): begin
        s_cen = 1'b0;
        s_oen = 1'b0;
        busy  = 1'b1;
      end
      (state_q == S_DRAIN): busy = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    base_d  = base_q;
    len_d   = len_q;
    op_d    = op_q;
    mode_d  = mode_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ddata_d = ddata_q;
    done_d  = done_q;
    fail_d  = fail_q;
    abrt_d  = abrt_q;
    err_d   = err_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;

    if (accept) begin
      base_d  = sta_addr;
      len_d   = length;
      op_d    = op_n;
      mode_d  = mode_n;
      pat_d   = pattern;
      cnt_d   = length;
      done_d  = 1'b0;
      fail_d  = 1'b0;
      abrt_d  = 1'b0;
      err_d   = '0;
      faddr_d = '0;
      fdata_d = '0;
      if (length != '0) begin
        addr_d = sta_addr;
        if (op_n != 2'b01)
          ddata_d = exp_data(sta_addr, mode_n, pattern);
      end
    end

    if (abort) begin
      abrt_d = 1'b1;
    end else if (state_q == S_WRITE) begin
      cnt_d = cnt_q - CW'(1);
      if (!last) begin
        addr_d  = addr_nx;
        ddata_d = exp_data(addr_nx, mode_q, pat_q);
      end else if (op_q == 2'b10) begin
        addr_d = base_q;
        cnt_d  = len_q;
      end
    end else if (state_q == S_READ) begin
      cnt_d = last ? CW'(RD_LAT) : cnt_q - CW'(1);
      if (!last)
        addr_d = addr_nx;
    end else if (state_q == S_DRAIN) begin
      cnt_d = cnt_q - CW'(1);
    end

    if (mismatch) begin
      err_d = (&err_q) ? err_q : err_q + 16'd1;
      if (!fail_q) begin
        fail_d  = 1'b1;
        faddr_d = pa_q[RD_LAT-1];
        fdata_d = s_qdata;
      end
    end

    if (state_d == S_DONE && state_q != S_DONE)
      done_d = 1'b1;
  end

  // Read-compare pipeline aligns address/expected data with s_qdata.
  always_comb begin
    pv_d[0] = (state_q == S_READ) && !abort;
    pa_d[0] = addr_q;
    pe_d[0] = exp_data(addr_q, mode_q, pat_q);
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1] && !abort;
      pa_d[i] = pa_q[i-1];
      pe_d[i] = pe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      mode_q  <= '0;
      pat_q   <= '0;
      addr_q  <= '0;
      ddata_q <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      abrt_q  <= 1'b0;
      err_q   <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
      pv_q    <= '0;
      pa_q    <= '{default: '0};
      pe_q    <= '{default: '0};
    end else begin
      start_q <= start;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      addr_q  <= addr_d;
      ddata_q <= ddata_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      abrt_q  <= abrt_d;
      err_q   <= err_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      pv_q    <= pv_d;
      pa_q    <= pa_d;
      pe_q    <= pe_d;
    end
  end

  assign s_addr    = addr_q;
  assign s_ddata   = ddata_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign aborted   = abrt_q;
  assign err_count = err_q;
  assign fail_addr = faddr_q;
  assign fail_data = fdata_q;

endmodule
